// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several byte-stream requesters share one uart_tx.
// A grant covers one whole message (up to req_last); a stalled owner is evicted after TIMEOUT_CYCLES.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 27000000
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_data_valid,
    input  logic                   tx_data_ready,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy,
    output logic                   timeout_pulse
);

    localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W:0]     NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;

    logic [NUM_REQ-1:0] gnt_oh_s;
    logic [NUM_REQ-1:0] ready_s;
    logic [7:0]         sel_data_s;
    logic               sel_valid_s;
    logic               sel_last_s;
    logic               lock_rdy_s;
    logic               tout_s;

    // First requester with valid set, searching upward from the one after the last owner.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] pick;
        logic [ID_W:0]   idx;
        logic            found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = {1'b0, last} + (ID_W + 1)'(i);
            idx = (idx >= NUM_REQ_W) ? (idx - NUM_REQ_W) : idx;
            if (!found && valid[idx[ID_W-1:0]]) begin
                pick  = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Route the granted requester's byte, valid and last onto internal signals.
    always_comb begin
        sel_data_s = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_oh_s[i] = (grant_q == ID_W'(i));
            sel_data_s  = sel_data_s | (req_data[8*i +: 8] & {8{gnt_oh_s[i]}});
        end
        sel_valid_s = |(req_valid & gnt_oh_s);
        sel_last_s  = |(req_last & gnt_oh_s);
    end

    assign lock_rdy_s = !valid_q || tx_data_ready;

    // Next-state logic for the IDLE / LOCK / DRAIN message FSM.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        ready_s = '0;
        tout_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = rr_pick(req_valid, last_q);
                    cnt_d   = '0;
                    state_d = LOCK;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK: begin
                ready_s = gnt_oh_s & {NUM_REQ{lock_rdy_s}};
                if (sel_valid_s && lock_rdy_s) begin
                    data_d  = sel_data_s;
                    valid_d = 1'b1;
                    state_d = sel_last_s ? DRAIN : LOCK;
                end else if (valid_q && tx_data_ready) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
                // The stall timer only runs while the owner presents nothing; back-pressure never evicts it.
                if (sel_valid_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    tout_s  = 1'b1;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (!valid_q || tx_data_ready) begin
                    valid_d = 1'b0;
                    last_d  = grant_q;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE) || valid_d;
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign req_ready     = ready_s;
    assign tx_data       = data_q;
    assign tx_data_valid = valid_q;
    assign grant_id      = grant_q;
    assign busy          = busy_q;
    assign timeout_pulse = tout_s;

endmodule
